// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder (with helper seq_chunk_ha)
// Description : Multi-cycle WIDTH-bit adder that processes CHUNK bits per
//               clock through a ripple chain of half-adder pairs. Uses a
//               start/busy/done handshake and reports sum, carry-out and
//               signed overflow.
// Options     : SEQ_ADDER_SUB_EN - adds an i_sub input; i_sub=1 computes
//               a + ~b + 1 (cin ignored), cout=1 meaning "no borrow".
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Half adder: the primitive cell of the chunk ripple chain.
// ----------------------------------------------------------------------------
module seq_chunk_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

// ----------------------------------------------------------------------------
// Sequential chunked adder.
// ----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  // Number of chunks and chunk-counter width (at least one bit).
  localparam int c_N  = WIDTH / CHUNK;
  localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_CW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_b_in;
  logic              w_cin_in;
  logic [31:0]       w_base;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK-1:0]  w_s_chunk;
  logic [CHUNK:0]    w_c;

  // A start is honoured whenever no add is in flight (IDLE or DONE).
  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_idx == c_LAST);

  // Subtraction is folded into the operands at acceptance time, so the
  // chunk datapath only ever adds.
`ifdef SEQ_ADDER_SUB_EN
  assign w_b_in   = i_sub ? ~i_b : i_b;
  assign w_cin_in = i_sub ? 1'b1 : i_cin;
`else
  assign w_b_in   = i_b;
  assign w_cin_in = i_cin;
`endif

  // Current chunk slice of the latched operands.
  assign w_base    = 32'(r_idx) * 32'(CHUNK);
  assign w_a_chunk = r_a[w_base +: CHUNK];
  assign w_b_chunk = r_b[w_base +: CHUNK];

  // Ripple chain: each bit is a full adder built from two half adders;
  // the chunk carry-in is the carry registered from the previous chunk.
  assign w_c[0] = r_carry;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_bit
      logic w_s1;
      logic w_c1;
      logic w_c2;

      seq_chunk_ha u_ha0 (
        .i_x (w_a_chunk[gi]),
        .i_y (w_b_chunk[gi]),
        .o_s (w_s1),
        .o_c (w_c1)
      );

      seq_chunk_ha u_ha1 (
        .i_x (w_s1),
        .i_y (w_c[gi]),
        .o_s (w_s_chunk[gi]),
        .o_c (w_c2)
      );

      assign w_c[gi+1] = w_c1 | w_c2;
    end
  endgenerate

  // State register; reset aborts any add in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: RUN ignores start, DONE can accept back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, then build sum one chunk
  // per cycle; flags are taken from the final chunk's carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: CHUNK] <= w_s_chunk;
      r_carry                <= w_c[CHUNK];
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_c[CHUNK];
        r_ovf  <= w_c[CHUNK] ^ w_c[CHUNK-1];
      end else begin
        r_idx  <= r_idx + c_CW'(1);
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_chunk_adder
// Description : Self-checking bench for seq_chunk_adder (CHUNK=8 and the
//               single-chunk CHUNK=WIDTH configuration side by side).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  localparam int W = 32;
  localparam int N = 4;   // W / 8

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
`ifdef SEQ_ADDER_SUB_EN
  logic          sub;
`endif

  logic          busy0, done0, cout0, ovf0;
  logic [W-1:0]  sum0;
  logic          busy1, done1, cout1, ovf1;
  logic [W-1:0]  sum1;

  int n_err = 0;
  int n_chk = 0;
  int n_done;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(start),
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
`ifdef SEQ_ADDER_SUB_EN
    .i_sub  (sub),
`endif
    .o_busy (busy0),
    .o_done (done0),
    .o_sum  (sum0),
    .o_cout (cout0),
    .o_ovf  (ovf0)
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(start),
    .i_a    (a),
    .i_b    (b),
    .i_cin  (cin),
`ifdef SEQ_ADDER_SUB_EN
    .i_sub  (sub),
`endif
    .o_busy (busy1),
    .o_done (done1),
    .o_sum  (sum1),
    .o_cout (cout1),
    .o_ovf  (ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the two's-complement operands.
  // Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc, input logic rs);
    logic [W-1:0] bo;
    logic         ci;
    logic [W:0]   t;
    logic         ov;
    bo = rs ? ~rb : rb;
    ci = rs ? 1'b1 : rc;
    t  = {1'b0, ra} + {1'b0, bo} + (W+1)'(ci);
    ov = (ra[W-1] == bo[W-1]) && (t[W-1] != ra[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  task automatic scramble();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // One complete add from IDLE; called #1 after a clock edge.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input string tag);
    logic [W+1:0] e;
    e     = ref_add(ta, tb_v, tc, ts);
    a     = ta;
    b     = tb_v;
    cin   = tc;
`ifdef SEQ_ADDER_SUB_EN
    sub   = ts;
`endif
    start = 1'b1;
    @(posedge clk); #1;               // accepting edge k
    start = 1'b0;
    scramble();                       // late input changes must be ignored
    chk({tag, ".busy_k"}, 64'(busy0), 64'(1));
    chk({tag, ".done_k"}, 64'(done0), 64'(0));
    for (int j = 1; j < N; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        chk({tag, ".c1_done"}, 64'(done1), 64'(1));
        chk({tag, ".c1_res"}, 64'({ovf1, cout1, sum1}), 64'(e));
      end
      chk({tag, ".busy_run"}, 64'({busy0, done0}), 64'(2'b10));
    end
    @(posedge clk); #1;               // edge k+N
    chk({tag, ".done"}, 64'({busy0, done0}), 64'(2'b01));
    chk({tag, ".res"}, 64'({ovf0, cout0, sum0}), 64'(e));
    @(posedge clk); #1;
    chk({tag, ".idle"}, 64'({busy0, done0}), 64'(2'b00));
    chk({tag, ".held"}, 64'({ovf0, cout0, sum0}), 64'(e));
  endtask

  initial begin
    logic [W+1:0] e1;
    logic [W+1:0] e2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #1;
    chk("reset_state", 64'({busy0, done0, cout0, ovf0, sum0}), 64'(0));
    chk("reset_state1", 64'({busy1, done1, cout1, ovf1, sum1}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed boundary cases
    run_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "carry_chunk");
    run_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "full_wrap");
    run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
    run_add(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_ovf");
    run_add(32'h00FF_FF00, 32'h0000_0100, 1'b1, 1'b0, "multi_carry");

    // Randomized adds
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_add(ra, rb, 1'($urandom), 1'b0, "rand");
    end

`ifdef SEQ_ADDER_SUB_EN
    run_add(32'd5, 32'd7, 1'b0, 1'b1, "sub_5_7");
    run_add(32'h8000_0000, 32'd1, 1'b1, 1'b1, "sub_ovf");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_add(ra, rb, 1'($urandom), 1'b1, "rand_sub");
    end
`endif

    // Reset two cycles into RUN
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_busy", 64'(busy0), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_abort", 64'({busy0, done0, cout0, ovf0, sum0}), 64'(0));
    chk("rst_abort1", 64'({busy1, done1, cout1, ovf1, sum1}), 64'(0));
    @(posedge clk); #1;
    chk("rst_hold", 64'({busy0, done0}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_nodone", 64'({busy0, done0}), 64'(0));
    @(posedge clk); #1;
    chk("rst_nodone2", 64'({busy0, done0, sum0}), 64'(0));
    run_add(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, "after_rst");

    // Handshake: start held through RUN, second add accepted in DONE
    e1 = ref_add(32'h0F0F_0F0F, 32'h1010_1010, 1'b1, 1'b0);
    e2 = ref_add(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    n_done = 0;
    a = 32'h0F0F_0F0F; b = 32'h1010_1010; cin = 1'b1;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1;               // accept op1
    for (int j = 1; j < N; j++) begin
      scramble();
`ifdef SEQ_ADDER_SUB_EN
      sub = 1'b0;
`endif
      @(posedge clk); #1;
      if (done0) n_done++;
      chk("hs_run_busy", 64'(busy0), 64'(1));
    end
    scramble();
    @(posedge clk); #1;               // in DONE for op1
    if (done0) n_done++;
    chk("hs_res1", 64'({ovf0, cout0, sum0}), 64'(e1));
    a = 32'hFFFF_0000; b = 32'h0001_0000; cin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;               // DONE edge accepts op2
    start = 1'b0;
    scramble();
    if (done0) n_done++;
    chk("hs_accept", 64'({busy0, done0}), 64'(2'b10));
    for (int j = 1; j < N; j++) begin
      @(posedge clk); #1;
      if (done0) n_done++;
    end
    @(posedge clk); #1;
    if (done0) n_done++;
    chk("hs_res2", 64'({ovf0, cout0, sum0}), 64'(e2));
    @(posedge clk); #1;
    if (done0) n_done++;
    chk("hs_idle", 64'({busy0, done0}), 64'(0));
    chk("hs_done_count", 64'(n_done), 64'(2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
